debounce_sync: RTL
==================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: number of consecutive identical synchronized samples needed to accept a new level; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port data_in, input, 1: raw asynchronous level (button/switch/external strobe); may glitch.
REQ-006 SHALL have port data_out, output, 1: debounced, clk-synchronous level; feeds the downstream posedge detector.
REQ-007 SHALL have port changed, output, 1: one-cycle pulse asserted in the cycle data_out takes a new value.

Function
REQ-008 SHALL pass data_in through a two-flop synchronizer (s0 <= data_in, s1 <= s0); only s1 drives the state machine.
REQ-009 SHALL implement four states: LOW (data_out=0), CHK_HIGH (data_out=0, counting), HIGH (data_out=1), CHK_LOW (data_out=1, counting).
REQ-010 In LOW, s1=1 SHALL move to CHK_HIGH with cnt <= 1; s1=0 SHALL hold LOW with cnt <= 0.
REQ-011 In CHK_HIGH, s1=0 SHALL return to LOW with cnt <= 0 and data_out unchanged; no pulse.
REQ-012 In CHK_HIGH, s1=1 with cnt = STABLE_CYCLES-1 SHALL move to HIGH, set data_out <= 1, pulse changed, and clear cnt; otherwise cnt SHALL increment.
REQ-013 HIGH and CHK_LOW SHALL mirror REQ-010 to REQ-012 with polarities inverted: a stable 0 for STABLE_CYCLES samples clears data_out and pulses changed.
REQ-014 data_out and changed SHALL be registered outputs, with no combinational path from data_in.
REQ-015 Latency: for a clean step on data_in settling before edge 1, data_out and changed SHALL update at edge STABLE_CYCLES+2, and not earlier.
REQ-016 A deviation of s1 lasting fewer than STABLE_CYCLES samples SHALL leave data_out unchanged and SHALL NOT pulse changed.
REQ-017 A glitch back to the current level during a count SHALL restart the count from zero; the count SHALL NOT be cumulative.
REQ-018 changed SHALL be high for exactly one cycle per accepted transition; two pulses SHALL be separated by at least STABLE_CYCLES cycles.
REQ-019 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While rst=1 at a clock edge, s0, s1, cnt, data_out and changed SHALL all be 0, and the state SHALL be LOW.
REQ-021 Reset asserted mid-count SHALL abandon the count; after release, a high data_in SHALL require the full STABLE_CYCLES+2 cycles before data_out=1.
REQ-022 If data_in is held high through reset, data_out SHALL rise STABLE_CYCLES+2 edges after the first edge with rst=0, with changed pulsing once.

Verification (STABLE_CYCLES=4)
REQ-023 Clean rise: data_in 0->1 before edge 1 -> data_out=1 and changed=1 at edge 6 only; changed=0 at edge 7.
REQ-024 Glitch reject: data_in high for 3 cycles, then low -> data_out stays 0 and changed never asserts.
REQ-025 Restart: from LOW, data_in high 3 cycles, low 1 cycle, then high -> data_out rises 6 edges after the second rise, not earlier.
REQ-026 Fall: from HIGH, data_in 1->0 -> data_out=0 with a one-cycle changed pulse at edge 6; a 2-cycle low glitch while HIGH -> no change.
REQ-027 Reset mid-count: rst=1 for 1 cycle during CHK_HIGH with data_in held high -> all outputs 0 in the reset cycle; data_out rises 6 edges after release.
REQ-028 Chatter: data_in toggles every cycle for 50 cycles, then holds 1 -> exactly one changed pulse, and data_out=1 at the end.

Source files
------------

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchronizer feeding a four-state stability filter for a raw level.
// Latency: a clean step on data_in appears on data_out/changed STABLE_CYCLES+2 edges later.
// Backpressure: none; free-running level filter, changed is a single-cycle pulse.
module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out,
  output logic changed
);

  localparam logic [1:0] ST_LOW      = 2'd0;
  localparam logic [1:0] ST_CHK_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_CHK_LOW  = 2'd3;

  // Terminal count: the sample that sees cnt at this value is the
  // STABLE_CYCLES-th consecutive sample of the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s0;
  logic             s1;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; only s1 is trusted by the filter below.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= data_in;
      s1 <= s0;
    end
  end

  // Stability filter: a candidate level must hold for STABLE_CYCLES samples;
  // any sample back at the current level abandons the count (not cumulative).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOW;
      cnt      <= '0;
      data_out <= 1'b0;
      changed  <= 1'b0;
    end else begin
      changed <= 1'b0;
      case (state)
        ST_LOW: begin
          if (s1) begin
            state <= ST_CHK_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_CHK_HIGH: begin
          if (!s1) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= ST_HIGH;
            data_out <= 1'b1;
            changed  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s1) begin
            state <= ST_CHK_LOW;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_CHK_LOW: begin
          if (s1) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= ST_LOW;
            data_out <= 1'b0;
            changed  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
